// File: rtl/hud_glyph_writer.sv
// ---------------------------------------------------------------------------
// hud_glyph_writer
//
// Copies one 8x16 glyph bitmap from the font ROM into one slot of the HUD
// text RAM. Slot s row r of the text RAM lives at address {s, r}. This is the
// same layout the HUD text pixel mapper reads. Game logic issues one request
// at a time through a valid/ready handshake. Each copy then runs for a fixed
// number of cycles.
//
// Timeline, with the accept edge as cycle 0:
//   cycle 1      READ0 : fetch row 0
//   cycles 2..16 COPY  : write row k, fetch row k+1 (k = 0..14)
//   cycle 17     LAST  : write row 15, no fetch, font_addr holds
//   cycle 18     DONE  : done pulse
//   cycle 19     IDLE  : req_ready high again
//
// Ports:
//   Clk        in   system clock; all state changes on the rising edge
//   Reset      in   synchronous, active-high reset
//   req_valid  in   copy request present
//   req_ready  out  high only in IDLE; the request is accepted when
//                   req_valid && req_ready
//   req_slot   in   destination slot, latched at accept
//   req_glyph  in   source glyph index, latched at accept
//   req_invert in   (only with HUD_GLYPH_INVERT_EN) writes inverted rows,
//                   latched at accept
//   font_addr  out  font ROM address = {glyph, row}
//   font_data  in   font ROM data, valid one cycle after font_addr
//   ram_we     out  text RAM write enable (asserted in COPY/LAST only)
//   ram_addr   out  text RAM address = {slot, row}
//   ram_wdata  out  text RAM write data (zero whenever ram_we is low)
//   busy       out  high from the cycle after accept through DONE
//   done       out  single-cycle pulse after the last row is written
//
// Optional feature macro: HUD_GLYPH_INVERT_EN
//   When this macro is defined, the module has the req_invert port.
//   When it is undefined, the port is absent and rows are copied unchanged.
// ---------------------------------------------------------------------------
module hud_glyph_writer #(
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned GLYPHS = 64,
  parameter int unsigned DATA_W = 8
) (
  input  logic                                      Clk,
  input  logic                                      Reset,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [$clog2(SLOTS)-1:0]                  req_slot,
  input  logic [$clog2(GLYPHS)-1:0]                 req_glyph,
`ifdef HUD_GLYPH_INVERT_EN
  input  logic                                      req_invert,
`endif
  output logic [$clog2(GLYPHS)+$clog2(ROWS)-1:0]    font_addr,
  input  logic [DATA_W-1:0]                         font_data,
  output logic                                      ram_we,
  output logic [$clog2(SLOTS)+$clog2(ROWS)-1:0]     ram_addr,
  output logic [DATA_W-1:0]                         ram_wdata,
  output logic                                      busy,
  output logic                                      done
);

  localparam int unsigned SLOT_W  = $clog2(SLOTS);
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned GLYPH_W = $clog2(GLYPHS);

  // COPY writes rows 0..ROWS-2. LAST writes the final row.
  localparam logic [ROW_W-1:0] ROW_PENULT = ROW_W'(ROWS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ0,
    S_COPY,
    S_LAST,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_nx;

  // Row currently being written. In READ0, LAST and DONE it also indexes the
  // fetch row.
  logic [ROW_W-1:0]     row;
  logic [ROW_W-1:0]     row_nx;
  logic [ROW_W-1:0]     font_row;

  logic [SLOT_W-1:0]    slot_q;
  logic [GLYPH_W-1:0]   glyph_q;
  logic [DATA_W-1:0]    row_data;
  logic                 accept;

  assign accept = req_valid && req_ready;

  // -------------------------------------------------------------------------
  // State and request registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      row     <= '0;
      slot_q  <= '0;
      glyph_q <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      if (accept) begin
        slot_q  <= req_slot;
        glyph_q <= req_glyph;
      end
    end
  end

`ifdef HUD_GLYPH_INVERT_EN
  logic invert_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      invert_q <= 1'b0;
    end else if (accept) begin
      invert_q <= req_invert;
    end
  end

  assign row_data = invert_q ? ~font_data : font_data;
`else
  assign row_data = font_data;
`endif

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    row_nx   = row;
    font_row = row;
    ram_we   = 1'b0;
    done     = 1'b0;

    case (state)
      S_IDLE: begin
        row_nx = '0;
        if (accept) begin
          state_nx = S_READ0;
        end
      end

      S_READ0: begin
        // Prefetch row 0. The first write happens next cycle using this data.
        state_nx = S_COPY;
      end

      S_COPY: begin
        // The fetch runs one row ahead of the write. The ROM is synchronous,
        // so the data for row k was addressed during the previous cycle.
        ram_we   = 1'b1;
        font_row = row + ROW_W'(1);
        row_nx   = row + ROW_W'(1);
        if (row == ROW_PENULT) begin
          state_nx = S_LAST;
        end
      end

      S_LAST: begin
        // The last row's data is already in flight, so no further fetch.
        // Row stays at its final value and does not wrap.
        ram_we   = 1'b1;
        state_nx = S_DONE;
      end

      S_DONE: begin
        done     = 1'b1;
        row_nx   = '0;
        state_nx = S_IDLE;
      end

      default: begin
        row_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Field concatenation keeps slot and row independent; no carry between them.
  assign font_addr = {glyph_q, font_row};
  assign ram_addr  = {slot_q, row};
  assign ram_wdata = ram_we ? row_data : '0;
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_hud_glyph_writer.sv
// ---------------------------------------------------------------------------
// tb_hud_glyph_writer
//
// Self-checking bench for hud_glyph_writer. A synchronous font ROM model is
// backed by an array. For each request the expected bus activity is derived
// directly from the accept-relative timeline: fetch of row r on cycle r+1,
// write of row r to {slot, r} on cycle r+2, done on cycle 18, ready on 19.
// Define HUD_GLYPH_INVERT_EN to also exercise the inverted copy.
// ---------------------------------------------------------------------------
module tb_hud_glyph_writer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_slot;
  logic [5:0] req_glyph;
  logic [9:0] font_addr;
  logic [7:0] font_data;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       busy;
  logic       done;
`ifdef HUD_GLYPH_INVERT_EN
  logic       req_invert;
`endif

  logic [7:0] rom_mem [0:1023];

  int n_total = 0;
  int n_pass  = 0;

  hud_glyph_writer #(
    .SLOTS (4),
    .ROWS  (16),
    .GLYPHS(64),
    .DATA_W(8)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_slot  (req_slot),
    .req_glyph (req_glyph),
`ifdef HUD_GLYPH_INVERT_EN
    .req_invert(req_invert),
`endif
    .font_addr (font_addr),
    .font_data (font_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  // Synchronous font ROM: data appears one cycle after the address.
  always @(posedge Clk) font_data <= rom_mem[font_addr];

  task automatic fill_rom_random();
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'($urandom);
  endtask

  task automatic fill_rom_row_pattern();
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'hA0 | 8'(i % 16);
  endtask

  task automatic set_invert(input logic v);
`ifdef HUD_GLYPH_INVERT_EN
    req_invert = v;
`else
    if (v) $display("note: invert requested but feature not built");
`endif
  endtask

  // Issue one request at a negedge and follow it cycle by cycle. It checks
  // every output against the timeline expected for (s, g, inv). After accept,
  // req_valid is set to `hold`. The slot/glyph inputs are either randomised
  // every cycle (toggle) or set to (ns, ng). If rst_at > 0, Reset is pulsed
  // in that cycle and the copy is expected to be abandoned.
  task automatic run_copy(input logic [1:0] s, input logic [5:0] g,
                          input logic inv, input bit hold, input bit toggle,
                          input logic [1:0] ns, input logic [5:0] ng,
                          input int rst_at, input string tag);
    logic [7:0] exp_d;
    logic [7:0] exp_a;
    logic [9:0] exp_fa;
    int         r;
    n_total++;
    if (req_ready !== 1'b1)
      $display("FAIL %s ready_before_accept got=%b want=1", tag, req_ready);
    else n_pass++;
    req_valid = 1'b1;
    req_slot  = s;
    req_glyph = g;
    set_invert(inv);
    @(posedge Clk);  // accept edge, cycle 0
    for (int c = 1; c <= 19; c++) begin
      @(negedge Clk);
      if (rst_at > 0 && c == rst_at + 1) begin
        n_total++;
        if (ram_we !== 1'b0)
          $display("FAIL %s rst_we c=%0d got=%b want=0", tag, c, ram_we);
        else n_pass++;
        n_total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
          $display("FAIL %s rst_idle c=%0d ready=%b busy=%b done=%b want=1/0/0",
                   tag, c, req_ready, busy, done);
        else n_pass++;
        Reset     = 1'b0;
        req_valid = 1'b0;
        break;
      end
      n_total++;
      if (ram_we !== (c >= 2 && c <= 17))
        $display("FAIL %s we c=%0d got=%b want=%b", tag, c, ram_we, (c >= 2 && c <= 17));
      else n_pass++;
      n_total++;
      if (done !== (c == 18))
        $display("FAIL %s done c=%0d got=%b want=%b", tag, c, done, (c == 18));
      else n_pass++;
      n_total++;
      if (req_ready !== (c == 19) || busy !== (c <= 18))
        $display("FAIL %s ready_busy c=%0d got=%b/%b want=%b/%b",
                 tag, c, req_ready, busy, (c == 19), (c <= 18));
      else n_pass++;
      if (c <= 17) begin
        r      = (c <= 16) ? c - 1 : 15;
        exp_fa = 10'(int'(g) * 16 + r);
        n_total++;
        if (font_addr !== exp_fa)
          $display("FAIL %s font_addr c=%0d got=%h want=%h", tag, c, font_addr, exp_fa);
        else n_pass++;
      end
      if (c >= 2 && c <= 17) begin
        r     = c - 2;
        exp_a = 8'(int'(s) * 16 + r);
        exp_d = rom_mem[int'(g) * 16 + r] ^ (inv ? 8'hFF : 8'h00);
        n_total++;
        if (ram_addr !== exp_a || ram_wdata !== exp_d)
          $display("FAIL %s write c=%0d got=%h:%h want=%h:%h",
                   tag, c, ram_addr, ram_wdata, exp_a, exp_d);
        else n_pass++;
      end
      req_valid = hold;
      if (toggle) begin
        req_slot  = 2'($urandom);
        req_glyph = 6'($urandom);
        set_invert(1'($urandom));
      end else begin
        req_slot  = ns;
        req_glyph = ng;
      end
      if (rst_at > 0 && c == rst_at) Reset = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    req_valid = 1'b0;
    req_slot  = '0;
    req_glyph = '0;
    set_invert(1'b0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      n_total++;
      if (req_ready !== 1'b1 || ram_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
        $display("FAIL reset_idle i=%0d ready=%b we=%b done=%b busy=%b want=1/0/0/0",
                 i, req_ready, ram_we, done, busy);
      else n_pass++;
    end
    n_total++;
    if (font_addr !== 10'h000 || ram_addr !== 8'h00 || ram_wdata !== 8'h00)
      $display("FAIL reset_buses got=%h/%h/%h want=000/00/00", font_addr, ram_addr, ram_wdata);
    else n_pass++;
  endtask

  task automatic test_single();
    fill_rom_row_pattern();
    run_copy(2'd2, 6'd5, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 0, "single");
  endtask

  task automatic test_back_to_back();
    fill_rom_random();
    run_copy(2'd0, 6'd1, 1'b0, 1'b1, 1'b0, 2'd3, 6'd63, 0, "b2b_first");
    run_copy(2'd3, 6'd63, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 0, "b2b_second");
  endtask

  task automatic test_input_change();
    fill_rom_random();
    run_copy(2'($urandom), 6'($urandom), 1'b0, 1'b1, 1'b1, 2'd0, 6'd0, 0, "toggle");
  endtask

  task automatic test_reset_mid_copy();
    fill_rom_random();
    run_copy(2'd1, 6'($urandom), 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 8, "rst_mid");
    @(negedge Clk);  // cycle 10
    n_total++;
    if (req_ready !== 1'b1 || done !== 1'b0 || ram_we !== 1'b0)
      $display("FAIL rst_mid_c10 ready=%b done=%b we=%b want=1/0/0", req_ready, done, ram_we);
    else n_pass++;
    run_copy(2'd1, 6'($urandom), 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 0, "after_rst");
  endtask

  task automatic test_reset_with_valid();
    Reset     = 1'b1;
    req_valid = 1'b1;
    req_slot  = 2'd3;
    req_glyph = 6'd9;
    @(negedge Clk);
    Reset     = 1'b0;
    req_valid = 1'b0;
    n_total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0)
      $display("FAIL rst_valid ready=%b busy=%b we=%b want=1/0/0", req_ready, busy, ram_we);
    else n_pass++;
    @(negedge Clk);
    n_total++;
    if (busy !== 1'b0 || ram_we !== 1'b0)
      $display("FAIL rst_valid_after busy=%b we=%b want=0/0", busy, ram_we);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      fill_rom_random();
      run_copy(2'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 0, "random");
    end
  endtask

  task automatic test_invert();
`ifdef HUD_GLYPH_INVERT_EN
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'h3C;
    run_copy(2'd2, 6'd7, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 0, "invert_3c");
    fill_rom_random();
    run_copy(2'($urandom), 6'($urandom), 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 0, "invert_rand");
    run_copy(2'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 0, "noinvert");
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_input_change();
    test_reset_mid_copy();
    test_reset_with_valid();
    test_random();
    test_invert();
    req_valid = 1'b0;
    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
